// File: rtl/pulse_burst_scheduler_pkg.sv
// rtl/pulse_burst_scheduler_pkg.sv - shared state encoding and default sizing for the burst scheduler
package pulse_burst_scheduler_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_CNT_W      = 10;
  localparam int DEF_TMO_W      = 16;
  localparam int DEF_GAP_CYCLES = 200;
  localparam int DEF_TIMEOUT    = 1000;

endpackage

// File: rtl/pulse_burst_scheduler_rr_arbiter.sv
// rtl/pulse_burst_scheduler_rr_arbiter.sv - round-robin pick over NUM_REQ requests
// The pointer only advances when the caller accepts the pick, so an unaccepted pick has no side effects.
module pulse_burst_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic               valid
);

  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     ptr_d;
  logic [IDX_W-1:0]     pick_idx;
  logic [2*NUM_REQ-1:0] rot;
  int                   pos;

  // Rotating a doubled copy puts the pointer position at bit 0, so the first set bit wins.
  always_comb begin
    rot      = {req, req} >> ptr_q;
    valid    = 1'b0;
    pick_idx = '0;
    grant_oh = '0;
    pos      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        pos   = int'(ptr_q) + k;
        if (pos >= NUM_REQ) begin
          pos = pos - NUM_REQ;
        end
        pick_idx = IDX_W'(pos);
      end
    end
    if (valid) begin
      grant_oh = NUM_REQ'(1) << pick_idx;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && valid) begin
      if (pick_idx == IDX_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = pick_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/pulse_burst_scheduler.sv
// rtl/pulse_burst_scheduler.sv - round-robin scheduler sharing one pulse-train generator between requesters
// Counts falling edges of the generator output and reports done or timeout fault per requester.
module pulse_burst_scheduler
  import pulse_burst_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int TMO_W      = DEF_TMO_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_num,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       fault,
  output logic                     busy,
  output logic                     pulse_en,
  output logic [CNT_W-1:0]         pulse_num,
  input  logic                     sign_in
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   pulse_num_q, pulse_num_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] fault_q, fault_d;
  logic               pulse_en_q, pulse_en_d;
  logic               sign_prev_q, sign_prev_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic               arb_valid;
  logic               arb_accept;
  logic [CNT_W-1:0]   sel_num;
  logic [CNT_W-1:0]   cnt_inc;
  logic               fall;
  logic               cnt_done;
  logic               tmo_hit;
  logic               gap_end;

  pulse_burst_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .accept   (arb_accept),
    .grant_oh (arb_oh),
    .valid    (arb_valid)
  );

  always_comb begin
    sel_num = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_oh[i]) begin
        sel_num = sel_num | req_num[i*CNT_W +: CNT_W];
      end
    end
  end

  // sign_in is already a clk-domain register in the generator, so no synchronizer here.
  assign fall     = sign_prev_q & ~sign_in;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign cnt_done = fall && (cnt_inc == pulse_num_q);
  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign gap_end  = (tmo_q == TMO_W'(GAP_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    pulse_num_d = pulse_num_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    grant_d     = grant_q;
    pulse_en_d  = pulse_en_q;
    req_ack_d   = '0;
    done_d      = '0;
    fault_d     = '0;
    arb_accept  = 1'b0;
    sign_prev_d = sign_in;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          arb_accept  = 1'b1;
          req_ack_d   = arb_oh;
          pulse_num_d = sel_num;
          cnt_d       = '0;
          tmo_d       = '0;
          if (sel_num != '0) begin
            state_d    = ST_RUN;
            grant_d    = arb_oh;
            pulse_en_d = 1'b1;
          end else begin
            // A zero-length burst completes immediately but still pays the gap.
            done_d  = arb_oh;
            state_d = ST_GAP;
          end
        end
      end

      ST_RUN: begin
        if (cnt_done) begin
          done_d     = grant_q;
          grant_d    = '0;
          pulse_en_d = 1'b0;
          cnt_d      = cnt_inc;
          tmo_d      = '0;
          state_d    = ST_GAP;
        end else if (fall) begin
          cnt_d = cnt_inc;
          tmo_d = '0;
        end else if (tmo_hit) begin
          fault_d    = grant_q;
          grant_d    = '0;
          pulse_en_d = 1'b0;
          tmo_d      = '0;
          state_d    = ST_GAP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_end) begin
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        pulse_en_d = 1'b0;
        tmo_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pulse_num_q <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      grant_q     <= '0;
      req_ack_q   <= '0;
      done_q      <= '0;
      fault_q     <= '0;
      pulse_en_q  <= 1'b0;
      sign_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_num_q <= pulse_num_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      grant_q     <= grant_d;
      req_ack_q   <= req_ack_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      pulse_en_q  <= pulse_en_d;
      sign_prev_q <= sign_prev_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign grant     = grant_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign busy      = (state_q != ST_IDLE);
  assign pulse_en  = pulse_en_q;
  assign pulse_num = pulse_num_q;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// tb/tb_pulse_burst_scheduler.sv - bench for pulse_burst_scheduler with a generator model and a transaction-level reference
module tb_pulse_burst_scheduler;

  localparam int N   = 4;
  localparam int CW  = 10;
  localparam int GAP = 200;
  localparam int TMO = 1000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*CW-1:0] req_num = '0;
  logic            sign_in = 1'b0;
  logic [N-1:0]    req_ack, grant, done, fault;
  logic            busy, pulse_en;
  logic [CW-1:0]   pulse_num;

  pulse_burst_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_num   (req_num),
    .req_ack   (req_ack),
    .grant     (grant),
    .done      (done),
    .fault     (fault),
    .busy      (busy),
    .pulse_en  (pulse_en),
    .pulse_num (pulse_num),
    .sign_in   (sign_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one = 1;
    return one << i;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({req_ack, grant, done, fault, busy, pulse_en, pulse_num});
  endfunction

  // Pulse generator: high for half a period, low for the rest, stops after pulse_num pulses.
  int period = 100;
  bit stuck  = 1'b0;
  int ph     = 0;
  int npulse = 0;
  always @(posedge clk) begin
    #1;
    if (!pulse_en) begin
      ph = 0; npulse = 0; sign_in = 1'b0;
    end else if (stuck || npulse >= int'(pulse_num)) begin
      sign_in = 1'b0;
    end else begin
      sign_in = (ph < period / 2);
      ph++;
      if (ph == period) begin ph = 0; npulse++; end
    end
  end

  // Reference: who owns the generator, pulses still owed, quiet cycles, gap cycles left.
  int            m_owner = -1;
  int            m_gap   = 0;
  int            m_rem   = 0;
  int            m_quiet = 0;
  int            m_rr    = 0;
  bit            m_prev  = 1'b0;
  logic [N-1:0]  e_ack = '0, e_done = '0, e_fault = '0;
  logic [CW-1:0] e_num = '0;

  always @(posedge clk) begin
    bit fell;
    int pick;
    fell = m_prev && !sign_in;
    e_ack = '0; e_done = '0; e_fault = '0;
    if (rst) begin
      m_owner = -1; m_gap = 0; m_rr = 0; m_prev = 1'b0; e_num = '0;
    end else begin
      m_prev = sign_in;
      if (m_owner >= 0) begin
        if (fell) begin
          m_rem--; m_quiet = 0;
          if (m_rem == 0) begin e_done = oh(m_owner); m_owner = -1; m_gap = GAP; end
        end else begin
          m_quiet++;
          if (m_quiet == TMO) begin e_fault = oh(m_owner); m_owner = -1; m_gap = GAP; end
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        pick = -1;
        for (int k = 0; k < N; k++)
          if (pick < 0 && req[(m_rr + k) % N]) pick = (m_rr + k) % N;
        if (pick >= 0) begin
          e_ack = oh(pick);
          m_rr  = (pick + 1) % N;
          e_num = req_num[pick*CW +: CW];
          if (e_num == 0) begin e_done = oh(pick); m_gap = GAP; end
          else begin m_owner = pick; m_rem = int'(e_num); m_quiet = 0; end
        end
      end
    end
  end

  // Per-cycle compare plus event log used by the directed checks.
  int           ack_cyc = 0, done_cyc = 0, fault_cyc = 0, idle_cyc = 0;
  logic [N-1:0] ack_val = '0, done_val = '0, fault_val = '0;
  int           n_ack = 0, n_done = 0, n_fault = 0, n_en_rise = 0, falls = 0;
  bit           en_prev = 1'b0, s_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0] eg;
    bit ee, eb;
    cyc++;
    eg = (m_owner >= 0) ? oh(m_owner) : {N{1'b0}};
    ee = (m_owner >= 0);
    eb = (m_owner >= 0) || (m_gap > 0);
    check("outputs", outs(), 64'({e_ack, eg, e_done, e_fault, eb, ee, e_num}));
    if (req_ack != 0) begin ack_cyc = cyc; ack_val = req_ack; n_ack++; falls = 0; end
    if (done != 0) begin done_cyc = cyc; done_val = done; n_done++; end
    if (fault != 0) begin fault_cyc = cyc; fault_val = fault; n_fault++; end
    if (pulse_en && !en_prev) n_en_rise++;
    if (pulse_en && s_prev && !sign_in) falls++;
    if (!busy && busy_prev) idle_cyc = cyc;
    en_prev = pulse_en; s_prev = sign_in; busy_prev = busy;
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_ack(input int budget);
    int start = n_ack;
    int t = 0;
    while (n_ack == start && t < budget) begin step(); t++; end
    if (n_ack == start) check("wait_ack_expired", 0, 1);
  endtask

  task automatic wait_end(input int budget);
    int start = n_done + n_fault;
    int t = 0;
    while (n_done + n_fault == start && t < budget) begin step(); t++; end
    if (n_done + n_fault == start) check("wait_end_expired", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy && t < budget) begin step(); t++; end
    if (busy) check("wait_idle_expired", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, nd, nf, ne, prev_done;
    logic [N-1:0] order [4];

    rst = 1'b1;
    repeat (3) step();
    check("reset_outputs", outs(), 0);
    rst = 1'b0;
    step();

    // Round robin with three requesters held high, count 2 each
    req_num[0*CW +: CW] = 2; req_num[1*CW +: CW] = 2; req_num[3*CW +: CW] = 2;
    req = 4'b1011;
    nd = n_done;
    prev_done = 0;
    for (int b = 0; b < 4; b++) begin
      wait_ack(600);
      order[b] = ack_val;
      if (b > 0) check("rr_gap_to_next_ack", 64'(ack_cyc - prev_done), 201);
      if (b == 3) req = '0;
      wait_end(600);
      check("rr_done_owner", done_val, order[b]);
      check("rr_burst_len", 64'(done_cyc - ack_cyc), 151);
      prev_done = done_cyc;
    end
    check("rr_order0", order[0], 4'b0001);
    check("rr_order1", order[1], 4'b0010);
    check("rr_order2", order[2], 4'b1000);
    check("rr_order3", order[3], 4'b0001);
    check("rr_done_count", 64'(n_done - nd), 4);
    wait_idle(400);
    step();

    // Single burst of 3 on requester 0
    req_num = '0;
    req_num[0*CW +: CW] = 3;
    req = 4'b0001;
    d = cyc;
    wait_ack(10);
    req = '0;
    check("single_ack_val", ack_val, 4'b0001);
    check("single_ack_latency", 64'(ack_cyc - d), 1);
    wait_end(1000);
    check("single_done_val", done_val, 4'b0001);
    check("single_done_time", 64'(done_cyc - ack_cyc), 251);
    check("single_falls", 64'(falls), 3);
    wait_idle(400);
    check("single_gap_len", 64'(idle_cyc - done_cyc), 200);
    step();

    // Zero count: ack and done together, generator never enabled
    req_num = '0;
    req = 4'b0100;
    ne = n_en_rise;
    wait_ack(10);
    req = '0;
    check("zero_ack_val", ack_val, 4'b0100);
    check("zero_done_val", done_val, 4'b0100);
    check("zero_done_same_cycle", 64'(done_cyc), 64'(ack_cyc));
    wait_idle(400);
    check("zero_no_enable", 64'(n_en_rise - ne), 0);
    check("zero_gap_len", 64'(idle_cyc - ack_cyc), 200);
    step();

    // Timeout on requester 1 with the generator output stuck low
    req_num[1*CW +: CW] = 5;
    stuck = 1'b1;
    req = 4'b0010;
    wait_ack(10);
    req = '0;
    nd = n_done;
    wait_end(1500);
    check("tmo_fault_val", fault_val, 4'b0010);
    check("tmo_fault_time", 64'(fault_cyc - ack_cyc), 1000);
    check("tmo_no_done", 64'(n_done - nd), 0);
    check("tmo_enable_low", 64'(pulse_en), 0);
    wait_idle(400);
    stuck = 1'b0;
    step();

    // Reset in the middle of the second pulse of a 5-pulse burst
    req_num = '0;
    req_num[2*CW +: CW] = 5;
    req = 4'b0100;
    wait_ack(10);
    req = '0;
    repeat (120) step();
    nd = n_done; nf = n_fault;
    rst = 1'b1;
    step();
    check("midreset_outputs", outs(), 0);
    rst = 1'b0;
    step();
    req_num[0*CW +: CW] = 1; req_num[3*CW +: CW] = 1;
    req = 4'b1001;
    wait_ack(10);
    req = '0;
    check("midreset_next_from_0", ack_val, 4'b0001);
    wait_end(400);
    wait_idle(400);
    check("midreset_done_count", 64'(n_done - nd), 1);
    check("midreset_no_fault", 64'(n_fault - nf), 0);
    step();

    // Maximum count with a fast generator
    period = 4;
    req_num = '0;
    req_num[0*CW +: CW] = 10'd1023;
    req = 4'b0001;
    wait_ack(10);
    req = '0;
    nd = n_done;
    wait_end(6000);
    check("max_done_val", done_val, 4'b0001);
    check("max_done_time", 64'(done_cyc - ack_cyc), 4091);
    check("max_falls", 64'(falls), 1023);
    wait_idle(400);
    check("max_done_once", 64'(n_done - nd), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
